reg_scoreboard: RTL
===================

# reg_scoreboard

- Tracks destination registers of in-flight long-latency instructions, such as loads and multi-cycle ops, that write back after the execute stage.
- Sits beside the decode/execute boundary and is the register-writer side of the RAW-hazard path: the forwarding unit bypasses results already in memory/writeback, while this block stalls consumers whose producer has not yet returned data.
- Also provides a same-cycle bypass when the completing write matches a source register.

## Interface

Parameters
- REGW, 5: register index width (32 architectural registers).
- MAX_OUTSTANDING, 2: maximum simultaneously tracked long-latency writes; range 1..15.

Ports
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- issue_valid_i, in, 1: an instruction in decode requests issue this cycle.
- issue_wr_i, in, 1: the issuing instruction writes rd.
- issue_long_i, in, 1: the issuing instruction is long-latency, so its rd must be tracked.
- issue_rd_i, in, REGW: destination of the issuing instruction.
- rs1_d_i, in, REGW: source 1 of the issuing instruction.
- rs2_d_i, in, REGW: source 2 of the issuing instruction.
- flush_i, in, 1: squash the decode instruction this cycle (branch taken).
- complete_valid_i, in, 1: a long-latency result is written back this cycle.
- complete_rd_i, in, REGW: destination of the completing write.
- stall_o, out, 1: hold decode; the issue is not accepted.
- forward_a_o, out, 1: rs1 takes the completing writeback data this cycle.
- forward_b_o, out, 1: rs2 takes the completing writeback data this cycle.
- busy_o, out, 2**REGW: per-register pending-write bits; bit 0 is always 0.
- outstanding_o, out, $clog2(MAX_OUTSTANDING+1): count of tracked writes.
- error_o, out, 1: sticky; set when a completion arrives for a non-busy register.

## Operation

Definitions
- cmp_hit(r) = complete_valid_i && complete_rd_i==r && r!=0.
- pend(r) = busy[r] && !cmp_hit(r).

stall_o is combinational. It is 1 when issue_valid_i && !flush_i and any of these holds:
- pend(rs1_d_i) — RAW hazard on source 1.
- pend(rs2_d_i) — RAW hazard on source 2.
- issue_wr_i && pend(issue_rd_i) — WAW hazard.
- issue_wr_i && issue_long_i && outstanding_o==MAX_OUTSTANDING && !complete_valid_i — capacity limit.

Bypass outputs
- forward_a_o = cmp_hit(rs1_d_i); forward_b_o = cmp_hit(rs2_d_i).
- Both are independent; both may be 1 together.
- Both are gated only by issue_valid_i.

Issue and completion
- accept = issue_valid_i && !flush_i && !stall_o && issue_wr_i && issue_long_i && issue_rd_i!=0.
- Completion is legal when busy[complete_rd_i]. It clears that bit and decrements the counter.
- Completion to a non-busy register, or to x0, changes no bit or count and sets error_o.
- Accept sets busy[issue_rd_i] and increments the counter.
- Same-cycle accept and completion: the counter is unchanged. If both target the same rd, the bit stays 1, because the set wins.
- The counter never exceeds MAX_OUTSTANDING and never underflows.

Other rules
- flush_i only suppresses acceptance in that cycle. Busy bits for already-issued instructions remain, since those instructions still complete.
- Short-latency writers (issue_long_i=0) are never tracked; the forwarding unit handles them.

## Timing

- Reset, synchronous: busy_o=0, outstanding_o=0, error_o=0 at the edge with rst_i=1.
- Reset asserted mid-operation discards all pending state. Completions returning after reset set error_o.
- stall_o, forward_a_o and forward_b_o are combinational, with zero latency from inputs.
- Busy bits and counter update on the edge after accept or completion. A dependent instruction stalls starting the cycle after its producer issues.
- Minimum producer-to-consumer distance without stall: the consumer is in decode in the same cycle as the completion, taking the bypass.

## Test plan

1. Load-use.
   - Stimulus: issue long x5; next cycle issue rs1=x5; complete x5 three cycles later.
   - Required: stall_o=1 for 2 cycles, then stall_o=0 with forward_a_o=1 in the completion cycle; busy_o[5]=0 afterwards.
2. Capacity.
   - Stimulus: MAX=2; issue long x1, then x2, then x3.
   - Required: x3 stalls with outstanding_o=2. When x1 completes, x3 is accepted in the same cycle and outstanding_o stays 2.
3. WAW plus same-rd issue/complete.
   - Stimulus: x7 busy; issue long x7 while x7 completes.
   - Required: no stall, busy_o[7] remains 1, count unchanged.
4. x0 handling.
   - Stimulus: issue long x0 with rs1=x0.
   - Required: no stall, busy_o=0, outstanding_o=0. A completion to x0 sets error_o.
5. Flush.
   - Stimulus: issue long x9 with flush_i=1.
   - Required: busy_o[9]=0, stall_o=0. An existing busy x4 is unaffected by the flush.
6. Reset mid-flight.
   - Stimulus: two outstanding ops, assert rst_i for one cycle.
   - Required: busy_o=0 and outstanding_o=0 next cycle. A late completion of x3 sets error_o=1.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard for in-flight long-latency writes
module reg_scoreboard #(
    parameter int REGW            = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  issue_valid_i,
    input  logic                                  issue_wr_i,
    input  logic                                  issue_long_i,
    input  logic [REGW-1:0]                       issue_rd_i,
    input  logic [REGW-1:0]                       rs1_d_i,
    input  logic [REGW-1:0]                       rs2_d_i,
    input  logic                                  flush_i,
    input  logic                                  complete_valid_i,
    input  logic [REGW-1:0]                       complete_rd_i,
    output logic                                  stall_o,
    output logic                                  forward_a_o,
    output logic                                  forward_b_o,
    output logic [2**REGW-1:0]                    busy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  error_o
);

    localparam int NREG = 2**REGW;
    localparam int CW   = $clog2(MAX_OUTSTANDING+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            err;

    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;
    logic pend_rs1;
    logic pend_rs2;
    logic pend_rd;
    logic at_cap;
    logic accept;
    logic cmp_legal;

    // Hazard detection: a source/destination is pending unless its producer returns right now.
    always_comb begin
        hit_rs1  = complete_valid_i && (complete_rd_i == rs1_d_i)    && (rs1_d_i != '0);
        hit_rs2  = complete_valid_i && (complete_rd_i == rs2_d_i)    && (rs2_d_i != '0);
        hit_rd   = complete_valid_i && (complete_rd_i == issue_rd_i) && (issue_rd_i != '0);
        pend_rs1 = busy[rs1_d_i]    && !hit_rs1;
        pend_rs2 = busy[rs2_d_i]    && !hit_rs2;
        pend_rd  = busy[issue_rd_i] && !hit_rd;
        at_cap   = (count == CNT_MAX);
        stall_o  = issue_valid_i && !flush_i &&
                   (pend_rs1 || pend_rs2 ||
                    (issue_wr_i && pend_rd) ||
                    (issue_wr_i && issue_long_i && at_cap && !complete_valid_i));
        forward_a_o = issue_valid_i && hit_rs1;
        forward_b_o = issue_valid_i && hit_rs2;
        accept    = issue_valid_i && !flush_i && !stall_o && issue_wr_i &&
                    issue_long_i && (issue_rd_i != '0);
        cmp_legal = complete_valid_i && busy[complete_rd_i] && (complete_rd_i != '0);
    end

    // Next busy vector and count; a same-rd set wins over the clear, and the
    // count saturates so an unmatched completion can never push it past the limit.
    always_comb begin
        busy_next = busy;
        if (cmp_legal) begin
            busy_next[complete_rd_i] = 1'b0;
        end
        if (accept) begin
            busy_next[issue_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;

        count_next = count;
        case ({accept, cmp_legal})
            2'b10:   if (count != CNT_MAX) count_next = count + CW'(1);
            2'b01:   if (count != '0)      count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Tracking state, with a sticky flag for completions that match nothing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            busy  <= busy_next;
            count <= count_next;
            if (complete_valid_i && !cmp_legal) begin
                err <= 1'b1;
            end
        end
    end

    assign busy_o        = busy;
    assign outstanding_o = count;
    assign error_o       = err;

endmodule
